fir_mac_scheduler: RTL and testbench

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

---
 rtl/fir_mac_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - round-robin multi-channel 4-tap FIR sharing one MAC
//
// Purpose: NCH channels each own a private 4-deep sample delay line. One
// 8x8 multiplier and one 18-bit accumulator are time-shared. A sample is
// accepted from one channel, the four taps are accumulated over four cycles,
// and the result is presented on the output stream.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid[NCH]          per-channel sample request
//   in_data[NCH*8]         per-channel samples, channel c at [8c+7:8c]
//   in_ready[NCH]          per-channel accept, one-hot or zero
//   coef_we/addr/wdata     coefficient write port (tap 0..3)
//   coef_err               one-cycle pulse when a coefficient write is dropped
//   out_valid/ready        result handshake
//   out_data[18], out_ch   filter result and the channel it belongs to
//   busy                   high whenever the scheduler is not idle
//
// Build option: define FIR_SCHED_COEF_WR_EN to make coefficients writable;
// otherwise they are the constants 4,3,2,1 and coef_err is tied low.
module fir_mac_scheduler #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*8-1:0]     in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 coef_we,
  input  logic [1:0]           coef_addr,
  input  logic [7:0]           coef_wdata,
  output logic                 coef_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [17:0]          out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    tap_q, tap_d;
  logic [CW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [17:0]   acc_q, acc_d;
  logic [7:0]    x_q [NCH][4];
  logic [7:0]    x_d [NCH][4];
  logic [7:0]    coef_v [4];

  logic          rr_found;
  logic [CW-1:0] rr_ch;
  logic [CW-1:0] cand;
  logic [NCH-1:0] rr_onehot;
  logic          accept;
  logic [15:0]   prod;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    rr_found  = 1'b0;
    rr_ch     = '0;
    cand      = '0;
    rr_onehot = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(last_q) + i) % NCH);
      if (!rr_found && in_valid[cand]) begin
        rr_found = 1'b1;
        rr_ch    = cand;
      end
    end
    if (rr_found) begin
      rr_onehot[rr_ch] = 1'b1;
    end
  end

  // rst_n gates the combinational ready so nothing is offered during reset.
  assign in_ready  = (state_q == S_IDLE && rst_n) ? rr_onehot : '0;
  assign accept    = |(in_ready & in_valid);

  assign out_valid = (state_q == S_OUT);
  assign out_data  = acc_q;
  assign out_ch    = gnt_q;
  assign busy      = (state_q != S_IDLE);

  assign prod = 16'(coef_v[tap_q]) * 16'(x_q[gnt_q][tap_q]);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    acc_d   = acc_q;
    x_d     = x_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int k = 3; k >= 1; k--) begin
            x_d[rr_ch][k] = x_q[rr_ch][k-1];
          end
          x_d[rr_ch][0] = in_data[8*rr_ch +: 8];
          acc_d   = '0;
          tap_d   = '0;
          gnt_d   = rr_ch;
          last_d  = rr_ch;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + 18'(prod);
        if (tap_q == 2'd3) begin
          state_d = S_OUT;
        end else begin
          tap_d = tap_q + 2'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      gnt_q   <= '0;
      last_q  <= CW'(NCH - 1);
      acc_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 4; k++) begin
          x_q[c][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

`ifdef FIR_SCHED_COEF_WR_EN
  logic [7:0] coef_q [4];
  logic [7:0] coef_d [4];
  logic       coef_err_q, coef_err_d;

  // A write only lands in an idle cycle that is not also accepting a sample.
  always_comb begin
    coef_d     = coef_q;
    coef_err_d = 1'b0;
    if (coef_we) begin
      if (state_q == S_IDLE && !accept) begin
        coef_d[coef_addr] = coef_wdata;
      end else begin
        coef_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q[0]  <= 8'd4;
      coef_q[1]  <= 8'd3;
      coef_q[2]  <= 8'd2;
      coef_q[3]  <= 8'd1;
      coef_err_q <= 1'b0;
    end else begin
      coef_q     <= coef_d;
      coef_err_q <= coef_err_d;
    end
  end

  assign coef_v   = coef_q;
  assign coef_err = coef_err_q;
`else
  logic coef_unused;

  assign coef_v[0]   = 8'd4;
  assign coef_v[1]   = 8'd3;
  assign coef_v[2]   = 8'd2;
  assign coef_v[3]   = 8'd1;
  assign coef_err    = 1'b0;
  assign coef_unused = &{1'b0, coef_we, coef_addr, coef_wdata};
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - randomized self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   in_valid;
  logic [NCH*8-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic             coef_we;
  logic [1:0]       coef_addr;
  logic [7:0]       coef_wdata;
  logic             coef_err;
  logic             out_valid;
  logic             out_ready;
  logic [17:0]      out_data;
  logic [CW-1:0]    out_ch;
  logic             busy;

  fir_mac_scheduler #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: sample history per channel, coefficient table, RR pointer.
  int hist [NCH][4];
  int coef_m [4];
  int last_m;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 4; k++) hist[c][k] = 0;
    coef_m[0] = 4; coef_m[1] = 3; coef_m[2] = 2; coef_m[3] = 1;
    last_m = NCH - 1;
  endfunction

  function automatic int rr_pick(input logic [NCH-1:0] m);
    for (int i = 1; i <= NCH; i++) begin
      if (m[(last_m + i) % NCH]) return (last_m + i) % NCH;
    end
    return -1;
  endfunction

  function automatic int model_accept(input int c, input int v);
    int s;
    for (int k = 3; k >= 1; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = v;
    last_m = c;
    s = 0;
    for (int k = 0; k < 4; k++) s += coef_m[k] * hist[c][k];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic coef_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk);
    #1 coef_we = 1'b0;
`ifdef FIR_SCHED_COEF_WR_EN
    coef_m[a] = v;
`endif
    @(negedge clk);
    check_eq("coef_err_idle", coef_err, 0);
  endtask

  // One full transaction: request, accept, MAC, optional output stall, drain.
  task automatic run_txn(input logic [NCH-1:0] mask, input logic [NCH*8-1:0] data,
                         input int hold, input bit wr_mac, output int got_ch);
    int g, expv, n;
    @(negedge clk);
    in_valid  = mask;
    in_data   = data;
    out_ready = (hold == 0);
    #1;
    g = rr_pick(mask);
    got_ch = g;
    check_eq("in_ready_grant", in_ready, (g < 0) ? 0 : (1 << g));
    if (g < 0) begin
      in_valid = '0;
      return;
    end
    @(posedge clk);
    expv = model_accept(g, int'(data[8*g +: 8]));
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 2 && wr_mac) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'd0;
      end
      if (n == 3) begin
        check_eq("mac_in_ready", in_ready, 0);
        check_eq("mac_busy", busy, 1);
        if (wr_mac) begin
`ifdef FIR_SCHED_COEF_WR_EN
          check_eq("coef_err_mac", coef_err, 1);
`else
          check_eq("coef_err_mac", coef_err, 0);
`endif
        end
        coef_we  = 1'b0;
        in_valid = '0;
      end
      if (n == 4 && wr_mac) check_eq("coef_err_clear", coef_err, 0);
      if (out_valid) break;
    end
    check_eq("latency", n, 5);
    check_eq("out_data", out_data, expv);
    check_eq("out_ch", out_ch, g);
    if (hold > 0) begin
      in_valid = mask;
      repeat (hold) begin
        @(negedge clk);
        check_eq("hold_data", out_data, expv);
        check_eq("hold_ch", out_ch, g);
        check_eq("hold_state", {out_valid, busy, in_ready}, {2'b11, {NCH{1'b0}}});
      end
      in_valid  = '0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("drain_idle", {out_valid, busy}, 0);
  endtask

  int ch;
  logic [NCH*8-1:0] dw;
  bit seen;

  initial begin
    rst_n = 1'b0;
    in_valid = '1; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk); #1;
    check_eq("rst_outputs", {in_ready, out_valid, busy, coef_err, out_ch}, 0);
    check_eq("rst_out_data", out_data, 0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 sends 10 -> 40
    run_txn(4'b0001, 32'd10, 0, 1'b0, ch);

    // ch1 history ramp, ch0 unaffected
    do_reset();
    for (int v = 1; v <= 4; v++) run_txn(4'b0010, 32'(v) << 8, 0, 1'b0, ch);
    run_txn(4'b0001, 32'd1, 0, 1'b0, ch);
    check_eq("ch0_first", out_data, 4);

    // output stall for 10 cycles
    run_txn(4'b0100, 32'h00AB_0000, 10, 1'b0, ch);

    // all requesting: round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 32'h1122_3344 + 32'(i), 0, 1'b0, ch);
      check_eq("rr_order", ch, i % NCH);
    end

    // coefficient writes, max-value filter, write during MAC
    for (int a = 0; a < 4; a++) coef_write(2'(a), 8'd255);
    for (int i = 0; i < 4; i++) run_txn(4'b0100, 32'h00FF_0000, 0, 1'b0, ch);
`ifdef FIR_SCHED_COEF_WR_EN
    check_eq("max_result", out_data, 260100);
`else
    check_eq("max_result", out_data, 2550);
`endif
    run_txn(4'b0100, 32'h0007_0000, 0, 1'b1, ch);
    run_txn(4'b0100, 32'h0009_0000, 0, 1'b0, ch);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      dw = {$urandom, $urandom};
      run_txn(4'($urandom_range(1, 15)), dw, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ch);
    end

    // reset during MAC tap 2
    @(negedge clk);
    in_valid = 4'b0010; in_data = 32'h0000_5500;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midmac_rst", {out_valid, busy, in_ready}, 0);
    in_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("no_stale_out", seen, 0);
    run_txn(4'b0001, 32'd10, 0, 1'b0, ch);
    check_eq("post_rst_40", out_data, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
